// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like memory responder.
// Holds size codes, FSM state encoding and the byte-enable mapping.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size code 3 falls into the default arm and behaves as a word.
  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lo;
      SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_like_mem_slave_be_ram.sv
// Single-port 32-bit RAM with per-byte write enables, synchronous read.
// Ports: i_addr word index, i_we/i_be/i_wdata write, i_re read, i_clr zero the output, o_rdata.
module be_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic                  i_clr,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  // Contents are deliberately not reset so they survive a reset pulse.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else if (i_clr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_like_mem_slave.sv
// Sram-like handshake responder backed by a byte-writable RAM with stall injection.
// Ports: cache_inst_req/wr/size/addr/wdata in; cache_inst_addr_ok/data_ok/rdata out.
module sram_like_mem_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int ADDR_LAT   = 0,
  parameter int DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_inst_req,
  input  logic        cache_inst_wr,
  input  logic [1:0]  cache_inst_size,
  input  logic [31:0] cache_inst_addr,
  input  logic [31:0] cache_inst_wdata,
  output logic [31:0] cache_inst_rdata,
  output logic        cache_inst_addr_ok,
  output logic        cache_inst_data_ok
);

  localparam int AW = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
  localparam logic [AW-1:0] ALAT = AW'(ADDR_LAT);
  localparam logic [3:0]    DLAT = 4'(DATA_LAT);

  state_t                r_state;
  logic [AW-1:0]         r_acnt;
  logic [3:0]            r_dcnt;
  logic                  r_data_ok;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  w_grant;
  logic                  w_to_resp;
  logic                  w_we;
  logic                  w_re;
  logic                  w_clr;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  // Upper address bits alias onto the RAM and are intentionally dropped.
  assign w_unused_addr = ^cache_inst_addr[31:ADDR_WIDTH+2];

  assign w_grant = (r_state == IDLE) & cache_inst_req & (r_acnt == ALAT);
  assign w_to_resp = (r_state == BUSY) & (r_dcnt == DLAT);

  assign w_idx = r_addr[ADDR_WIDTH+1:2];
  assign w_be  = byte_en(r_size, r_addr[1:0]);

  // Write commits at the end of RESP; a reset there drops r_state first.
  assign w_we  = (r_state == RESP) & r_wr;
  assign w_re  = w_to_resp & ~r_wr;
  assign w_clr = w_to_resp & r_wr;

  assign cache_inst_addr_ok = w_grant;
  assign cache_inst_data_ok = r_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acnt    <= '0;
      r_dcnt    <= '0;
      r_data_ok <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_wr    <= cache_inst_wr;
            r_size  <= cache_inst_size;
            r_addr  <= cache_inst_addr[ADDR_WIDTH+1:0];
            r_wdata <= cache_inst_wdata;
            r_dcnt  <= 4'd1;
            r_acnt  <= '0;
            r_state <= BUSY;
          end else if (!cache_inst_req) begin
            r_acnt <= '0;
          end else if (r_acnt != ALAT) begin
            r_acnt <= r_acnt + AW'(1);
          end
        end
        BUSY: begin
          r_dcnt <= r_dcnt + 4'd1;
          if (w_to_resp) begin
            r_state   <= RESP;
            r_data_ok <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  be_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_idx),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_wdata(r_wdata),
    .i_re   (w_re),
    .i_clr  (w_clr),
    .o_rdata(cache_inst_rdata)
  );

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Self-checking bench for sram_like_mem_slave: two instances (ADDR_LAT 0 and 3)
// share the request bus; instance 0 is tracked by a transaction-level model.
module tb_sram_like_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rd0, rd3;
  logic        aok0, aok3, dok0, dok3;

  int checks = 0;
  int errors = 0;

  logic        s_aok0, s_dok0, s_aok3, s_dok3;
  logic [31:0] s_rd0, s_rd3;

  localparam int DL = 2;

  logic [31:0] mm [int];
  bit          m_pend = 1'b0;
  int          m_cyc = 0;
  bit          m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  always #5 clk = ~clk;

  sram_like_mem_slave #(
    .ADDR_WIDTH(12), .ADDR_LAT(0), .DATA_LAT(DL)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .cache_inst_req(req), .cache_inst_wr(wr),
    .cache_inst_size(size), .cache_inst_addr(addr),
    .cache_inst_wdata(wdata), .cache_inst_rdata(rd0),
    .cache_inst_addr_ok(aok0), .cache_inst_data_ok(dok0)
  );

  sram_like_mem_slave #(
    .ADDR_WIDTH(12), .ADDR_LAT(3), .DATA_LAT(DL)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .cache_inst_req(req), .cache_inst_wr(wr),
    .cache_inst_size(size), .cache_inst_addr(addr),
    .cache_inst_wdata(wdata), .cache_inst_rdata(rd3),
    .cache_inst_addr_ok(aok3), .cache_inst_data_ok(dok3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample at negedge, compare against the model, then return at posedge+1.
  task automatic tick();
    bit          e_aok, e_dok, en;
    int          i;
    logic [31:0] wv;
    @(negedge clk);
    s_aok0 = aok0; s_dok0 = dok0; s_rd0 = rd0;
    s_aok3 = aok3; s_dok3 = dok3; s_rd3 = rd3;
    if (rst) begin
      m_pend = 1'b0;
      chk("rst_addr_ok", {31'b0, aok0}, 32'd0);
      chk("rst_data_ok", {31'b0, dok0}, 32'd0);
    end else begin
      e_aok = req && !m_pend;
      e_dok = m_pend && (m_cyc == DL + 1);
      chk("model_addr_ok", {31'b0, aok0}, {31'b0, e_aok});
      chk("model_data_ok", {31'b0, dok0}, {31'b0, e_dok});
      if (e_dok) begin
        i = int'(m_addr[13:2]);
        if (m_wr) begin
          chk("model_wr_rdata", rd0, 32'h0);
          wv = mm.exists(i) ? mm[i] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (m_size == 2'd0) en = (b == int'(m_addr[1:0]));
            else if (m_size == 2'd1) en = ((b / 2) == int'(m_addr[1]));
            else en = 1'b1;
            if (en) wv[8*b +: 8] = m_wdata[8*b +: 8];
          end
          mm[i] = wv;
        end else if (mm.exists(i)) begin
          chk("model_rd_rdata", rd0, mm[i]);
        end
        m_pend = 1'b0;
      end
      if (e_aok) begin
        m_pend = 1'b1; m_cyc = 0;
        m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
      end
      if (m_pend) m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit sel, input bit w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output int gc, output int dl, output logic [31:0] rdv);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    gc = 0;
    tick();
    while (!(sel ? s_aok3 : s_aok0) && gc < 40) begin
      gc++;
      tick();
    end
    req = 1'b0; wr = ~w; addr = ~a; wdata = ~d;
    dl = 1;
    tick();
    while (!(sel ? s_dok3 : s_dok0) && dl < 40) begin
      dl++;
      tick();
    end
    rdv = sel ? s_rd3 : s_rd0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int          gc, dl, c, dk;
    logic [31:0] rv;
    int          ga[$], da[$], g3[$], d3[$];
    logic [31:0] rds[$];

    for (int k = 0; k < 3; k++) tick();
    chk("reset_rdata0", s_rd0, 32'h0);
    chk("reset_rdata3", s_rd3, 32'h0);
    chk("reset_aok3", {31'b0, s_aok3}, 32'd0);
    chk("reset_dok3", {31'b0, s_dok3}, 32'd0);
    rst = 1'b0;
    tick();

    txn(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, gc, dl, rv);
    chk("wr_latency", dl, 3);
    chk("wr_rdata_zero", rv, 32'h0);
    txn(0, 1, 2'd2, 32'h20, 32'h11223344, gc, dl, rv);
    txn(0, 1, 2'd2, 32'h40, 32'h12345678, gc, dl, rv);
    txn(0, 1, 2'd2, 32'h00, 32'h01010101, gc, dl, rv);
    txn(0, 1, 2'd2, 32'h04, 32'h02020202, gc, dl, rv);

    txn(0, 0, 2'd2, 32'h10, 32'h0, gc, dl, rv);
    chk("rd_grant_cycle", gc, 0);
    chk("rd_latency", dl, 3);
    chk("rd_data", rv, 32'hDEADBEEF);

    txn(0, 1, 2'd0, 32'h22, 32'h00AB0000, gc, dl, rv);
    txn(0, 0, 2'd2, 32'h20, 32'h0, gc, dl, rv);
    chk("byte_write", rv, 32'h11AB3344);
    txn(0, 1, 2'd1, 32'h20, 32'h0000CDEF, gc, dl, rv);
    txn(0, 0, 2'd2, 32'h20, 32'h0, gc, dl, rv);
    chk("half_write_lo", rv, 32'h11ABCDEF);
    txn(0, 1, 2'd1, 32'h23, 32'h77660000, gc, dl, rv);
    txn(0, 0, 2'd2, 32'h20, 32'h0, gc, dl, rv);
    chk("half_write_hi", rv, 32'h7766CDEF);

    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (s_aok0) ga.push_back(k);
      if (s_dok0) begin da.push_back(k); rds.push_back(s_rd0); end
      if (k == 0) addr = 32'h4;
    end
    idle(5);
    chk("b2b_grants", ga.size(), 3);
    chk("b2b_grant1", ga[1], 4);
    chk("b2b_dok0", da[0], 3);
    chk("b2b_dok1", da[1], 7);
    chk("b2b_rd0", rds[0], 32'h01010101);
    chk("b2b_rd1", rds[1], 32'h02020202);

    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_aok3) g3.push_back(k);
      if (s_dok3) d3.push_back(k);
    end
    idle(6);
    chk("stall_grants", g3.size(), 2);
    chk("stall_first", g3[0], 3);
    chk("stall_regrant", g3[1], 10);
    chk("stall_dok", d3[0], 6);

    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
    tick();
    chk("drop_c0", {31'b0, s_aok3}, 32'd0);
    tick();
    chk("drop_c1", {31'b0, s_aok3}, 32'd0);
    req = 1'b0;
    tick();
    req = 1'b1;
    c = 0;
    tick();
    while (!s_aok3 && c < 40) begin
      c++;
      tick();
    end
    chk("drop_restart", c, 3);
    idle(6);

    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40;
    wdata = 32'hCAFEF00D;
    tick();
    chk("abort_grant", {31'b0, s_aok0}, 32'd1);
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dk = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_dok0) dk++;
    end
    chk("abort_no_dok", dk, 0);
    chk("abort_rdata_rst", s_rd0, 32'h0);
    txn(0, 0, 2'd2, 32'h40, 32'h0, gc, dl, rv);
    chk("abort_no_commit", rv, 32'h12345678);

    txn(0, 1, 2'd3, 32'h4000, 32'hA5A5A5A5, gc, dl, rv);
    txn(0, 0, 2'd2, 32'h0000, 32'h0, gc, dl, rv);
    chk("alias_size3", rv, 32'hA5A5A5A5);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
